// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: registered divided clock plus period tick strobe.
// Latency: outputs registered; a captured divisor takes effect at the next enabled wrap.
// Backpressure: none; en=0 freezes counter and clock output, and forces tick low.
//
// Ports:
//   clk, rst     - system clock, asynchronous active-high reset
//   en           - count enable
//   div_in       - requested divisor (0 and 1 are clamped to 2)
//   div_load     - one-cycle strobe capturing div_in as the pending divisor
//   clk_spori    - divided clock, high ceil(D/2) and low floor(D/2) cycles
//   tick         - one-cycle strobe in the first cycle of each new period
//   div_active   - divisor currently in use
//   div_pending  - a captured divisor is waiting for the next period boundary
//   sync         - (only with CLK_DIV_PROG_SYNC_EN) restart the period at cnt=0
//
// Optional feature macro: CLK_DIV_PROG_SYNC_EN adds the sync input for
// phase-aligning several dividers.
module clk_div_prog #(
  parameter int WIDTH       = 16,
  parameter int DIV_DEFAULT = 2
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CLK_DIV_PROG_SYNC_EN
  input  logic             sync,
`endif
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_spori,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             div_pending
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_DEFAULT);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] pend_val;
  logic [WIDTH-1:0] load_val;
  logic             wrap;
  logic             restart;
  logic             apply;

  always_comb begin
    half     = div_active >> 1;
    wrap     = (cnt == (div_active - ONE));
    cnt_next = wrap ? '0 : (cnt + ONE);
    load_val = (div_in < TWO) ? TWO : div_in;
`ifdef CLK_DIV_PROG_SYNC_EN
    restart  = sync;
`else
    restart  = 1'b0;
`endif
    // A divisor is only swapped in where a fresh period begins at cnt=0,
    // so no truncated or stretched period ever reaches clk_spori.
    apply    = div_pending && (restart || (en && wrap));
  end

  // Counter and output waveform
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      clk_spori <= 1'b0;
      tick      <= 1'b0;
    end else if (restart) begin
      cnt       <= '0;
      clk_spori <= 1'b0;
      tick      <= 1'b0;
    end else if (en) begin
      cnt       <= cnt_next;
      clk_spori <= (cnt_next >= half);
      tick      <= wrap;
    end else begin
      tick      <= 1'b0;
    end
  end

  // Divisor capture and apply. A load on the same edge as an apply lands in
  // the pending register after the swap, so it waits for the following
  // boundary and div_pending stays set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_active  <= DIV_RST;
      pend_val    <= DIV_RST;
      div_pending <= 1'b0;
    end else begin
      if (apply) begin
        div_active <= pend_val;
      end
      if (div_load) begin
        pend_val    <= load_val;
        div_pending <= 1'b1;
      end else if (apply) begin
        div_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         sync;
  logic         en;
  logic [W-1:0] div_in;
  logic         div_load;
  logic         clk_spori;
  logic         tick;
  logic [W-1:0] div_active;
  logic         div_pending;

  clk_div_prog #(.WIDTH(W), .DIV_DEFAULT(2)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef CLK_DIV_PROG_SYNC_EN
    .sync       (sync),
`endif
    .en         (en),
    .div_in     (div_in),
    .div_load   (div_load),
    .clk_spori  (clk_spori),
    .tick       (tick),
    .div_active (div_active),
    .div_pending(div_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         clk_spori;
    logic         tick;
    logic [W-1:0] div_active;
    logic         div_pending;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [W-1:0] m_cnt, m_d, m_pv;
  logic         m_pend, m_clk, m_tick;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt  = '0;
    m_d    = W'(2);
    m_pv   = W'(2);
    m_pend = 1'b0;
    m_clk  = 1'b0;
    m_tick = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic l, input logic [W-1:0] d, input logic s);
    logic [W-1:0] nxt;
    logic [W-1:0] old_pv;
    logic         wr;
    logic         app;
    exp_t         x;
    old_pv = m_pv;
    wr     = (m_cnt == m_d - 1);
    app    = m_pend && (s || (e && wr));
    if (s) begin
      m_cnt = '0; m_clk = 1'b0; m_tick = 1'b0;
    end else if (e) begin
      nxt    = wr ? '0 : m_cnt + 1'b1;
      m_clk  = (nxt >= (m_d >> 1));
      m_tick = wr;
      m_cnt  = nxt;
    end else begin
      m_tick = 1'b0;
    end
    if (app) m_d = old_pv;
    if (l) begin
      m_pv   = (d < 2) ? W'(2) : d;
      m_pend = 1'b1;
    end else if (app) begin
      m_pend = 1'b0;
    end
    x.clk_spori   = m_clk;
    x.tick        = m_tick;
    x.div_active  = m_d;
    x.div_pending = m_pend;
    exp_q.push_back(x);
  endtask

  // Drive one clock of stimulus, then score the DUT against the popped expectation.
  task automatic cycle(input logic e, input logic l, input logic [W-1:0] d, input logic s);
    exp_t x;
    en = e; div_load = l; div_in = d; sync = s;
    model_step(e, l, d, s);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    chk("clk_spori",   clk_spori,   x.clk_spori);
    chk("tick",        tick,        x.tick);
    chk("div_active",  div_active,  x.div_active);
    chk("div_pending", div_pending, x.div_pending);
    en = 1'b1; div_load = 1'b0; div_in = '0; sync = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, 1'b0);
  endtask

  // Run enabled until the reference counter reaches target; bounded.
  task automatic run_to_cnt(input logic [W-1:0] target);
    for (int i = 0; i < 200 && m_cnt != target; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    if (m_cnt != target) chk("run_to_cnt_timeout", m_cnt, target);
  endtask

  task automatic run_until_applied();
    for (int i = 0; i < 200 && m_pend; i++) cycle(1'b1, 1'b0, '0, 1'b0);
    if (m_pend) chk("apply_timeout", 32'(m_pend), 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_clk_spori"},   clk_spori,   0);
    chk({tag, "_tick"},        tick,        0);
    chk({tag, "_div_active"},  div_active,  2);
    chk({tag, "_div_pending"}, div_pending, 0);
  endtask

  int highs, ticks;

  initial begin
    rst = 1'b1; en = 1'b1; div_in = '0; div_load = 1'b0; sync = 1'b0;
    model_reset();
    #2;
    check_reset_values("reset");
    #1 rst = 1'b0;

    // D=2: clk_spori toggles every edge, tick on even cycles
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b0);
      chk("d2_clk",  clk_spori, 32'(i % 2));
      chk("d2_tick", tick,      32'(i % 2 == 0));
    end

    // Load 5 at cnt=0; current D=2 period completes first
    cycle(1'b1, 1'b1, W'(5), 1'b0);
    chk("d5_pending", div_pending, 1);
    chk("d5_still_2", div_active, 2);
    run_until_applied();
    chk("d5_active", div_active, 5);
    highs = 0; ticks = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b0);
      highs += 32'(clk_spori);
      ticks += 32'(tick);
    end
    chk("d5_highs", highs, 6);
    chk("d5_ticks", ticks, 2);

    // Clamping of 0 and 1
    cycle(1'b1, 1'b1, W'(0), 1'b0);
    run_until_applied();
    chk("clamp0", div_active, 2);
    run(3);
    cycle(1'b1, 1'b1, W'(1), 1'b0);
    run_until_applied();
    chk("clamp1", div_active, 2);
    run(2);

    // Back-to-back loads: last write wins
    run_to_cnt(W'(0));
    cycle(1'b1, 1'b1, W'(7), 1'b0);
    cycle(1'b1, 1'b1, W'(4), 1'b0);
    run_until_applied();
    chk("last_wins", div_active, 4);
    run(9);

    // Load on the wrap edge: one more full period with old D
    run_to_cnt(m_d - 1'b1);
    cycle(1'b1, 1'b1, W'(3), 1'b0);
    chk("wrap_load_pending", div_pending, 1);
    chk("wrap_load_old_d", div_active, 4);
    run(3);
    chk("wrap_load_still_old", div_active, 4);
    run_until_applied();
    chk("wrap_load_new_d", div_active, 3);
    run(7);

    // D=6, freeze at cnt=3 for 10 cycles, then resume
    cycle(1'b1, 1'b1, W'(6), 1'b0);
    run_until_applied();
    run_to_cnt(W'(3));
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b0);
      chk("freeze_tick", tick, 0);
      chk("freeze_clk", clk_spori, 1);
    end
    run(14);

    // Pending divisor held across en=0
    cycle(1'b0, 1'b1, W'(8), 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0, 1'b0);
    chk("held_pending", div_pending, 1);
    run_until_applied();
    chk("held_applied", div_active, 8);
    run(5);

    // Reset mid-period discards pending divisor
    cycle(1'b1, 1'b1, W'(9), 1'b0);
    run(2);
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    model_reset();
    #1 rst = 1'b0;
    run(6);

`ifdef CLK_DIV_PROG_SYNC_EN
    // Sync pulse at cnt=4, D=8, pending=3
    cycle(1'b1, 1'b1, W'(8), 1'b0);
    run_until_applied();
    run_to_cnt(W'(2));
    cycle(1'b1, 1'b1, W'(3), 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1);
    chk("sync_clk", clk_spori, 0);
    chk("sync_tick", tick, 0);
    chk("sync_active", div_active, 3);
    chk("sync_pending", div_pending, 0);
    run(6);
`endif

    if (exp_q.size() != 0) chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
